// File: rtl/lc3b_types.sv
// lc3b_types: shared memory-interface types and defaults for the LC-3b memory responder.
package lc3b_types;
  typedef logic [1:0] lc3b_mem_wmask;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} lc3b_mem_state;
  localparam int LC3B_MEM_LATENCY_DEFAULT = 4;
endpackage

// File: rtl/lc3b_mem_array.sv
// lc3b_mem_array: 2**ADDR_W x 16 single-port array, per-byte write enables, registered read.
module lc3b_mem_array
  import lc3b_types::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  lc3b_mem_wmask     we,
  input  logic [15:0]       wdata,
  input  logic              re,
  output logic [15:0]       rdata
);
  logic [15:0] mem [2**ADDR_W];
  logic [15:0] rdata_q, rdata_d;
  always_comb rdata_d = re ? mem[addr] : rdata_q;
  always_ff @(posedge clk) begin
    if (we[0]) mem[addr][7:0] <= wdata[7:0];
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
  end
  always_ff @(posedge clk) rdata_q <= rst ? 16'h0000 : rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder: fixed-latency LC-3b memory responder; LC3B_MEM_PROTO_CHECK_EN adds a sticky protocol checker.
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY = LC3B_MEM_LATENCY_DEFAULT,
  parameter int ADDR_W  = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_enable,
  input  logic [15:0]   mem_address,
  input  logic [15:0]   mem_wdata,
  output logic [15:0]   mem_rdata,
  output logic          mem_resp,
  output logic          busy,
  output logic          proto_err
);
  lc3b_mem_state     state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [15:0]       wdata_q, wdata_d;
  lc3b_mem_wmask     be_q, be_d;
  logic              wr_q, wr_d, resp_q, busy_q;
  logic              req, accept, re;
  lc3b_mem_wmask     we;
  assign req    = mem_read | mem_write;
  assign accept = (state_q == IDLE) && req;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = accept ? mem_address[ADDR_W:1] : idx_q;
    wdata_d = accept ? mem_wdata : wdata_q;
    be_d    = accept ? mem_byte_enable : be_q;
    wr_d    = accept ? mem_write : wr_q;
    if (accept) begin
      state_d = (LATENCY == 1) ? RESP : WAIT;
      cnt_d   = 4'(LATENCY - 1);
    end else if (state_q == WAIT) begin
      state_d = (cnt_q == 4'd1) ? RESP : WAIT;
      cnt_d   = cnt_q - 4'd1;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end
  // Read samples the array on the edge entering RESP; write commits on the edge leaving it.
  assign re = (state_q != RESP) && (state_d == RESP) && !wr_d && !rst;
  assign we = (state_q == RESP && wr_q && !rst) ? be_q : 2'b00;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= state_d == RESP;
      busy_q  <= state_d != IDLE;
    end
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
    wr_q    <= wr_d;
  end
  lc3b_mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .rst   (rst),
    .addr  ((state_q == IDLE) ? mem_address[ADDR_W:1] : idx_q),
    .we    (we),
    .wdata (wdata_q),
    .re    (re),
    .rdata (mem_rdata)
  );
  assign mem_resp = resp_q;
  assign busy     = busy_q;
`ifdef LC3B_MEM_PROTO_CHECK_EN
  logic [15:0] addr_q, addr_d;
  logic        err_q, err_d;
  always_comb begin
    addr_d = accept ? mem_address : addr_q;
    err_d  = err_q | (accept && mem_read && mem_write)
           | (state_q == WAIT && (!req || mem_address != addr_q || mem_wdata != wdata_q));
  end
  always_ff @(posedge clk) begin
    err_q  <= rst ? 1'b0 : err_d;
    addr_q <= addr_d;
  end
  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_lc3b_mem_responder.sv
// tb_lc3b_mem_responder: randomized and directed checks of lc3b_mem_responder against a word-array model.
module tb_lc3b_mem_responder;
  localparam int LAT = 4;
`ifdef LC3B_MEM_PROTO_CHECK_EN
  localparam logic [15:0] PE = 16'd1;
`else
  localparam logic [15:0] PE = 16'd0;
`endif
  logic        clk = 0, rst = 0, mem_read = 0, mem_write = 0, mem_resp, busy, proto_err;
  logic [1:0]  mem_byte_enable = 0;
  logic [15:0] mem_address = 0, mem_wdata = 0, mem_rdata;
  logic [15:0] mdl [1024];
  logic [15:0] last_rd = 0;
  int n_cmp = 0, n_bad = 0;
  lc3b_mem_responder #(.LATENCY(LAT), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .busy(busy), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1; mem_read = 0; mem_write = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    last_rd = 0;
  endtask
  task automatic xact(input bit rd, input bit wr, input logic [1:0] be, input logic [15:0] a, input logic [15:0] d);
    int n;
    logic [9:0] i;
    logic [15:0] exp;
    i = a[10:1];
    exp = mdl[i];
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_address = a; mem_wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_acc", {15'd0, busy}, 16'd1);
    end while (!mem_resp && n < 40);
    check("latency", 16'(n), 16'(LAT));
    mem_read = 0; mem_write = 0;
    if (wr) begin
      if (be[0]) mdl[i][7:0] = d[7:0];
      if (be[1]) mdl[i][15:8] = d[15:8];
    end else begin
      check("rdata", mem_rdata, exp);
      last_rd = exp;
    end
    @(negedge clk);
    check("resp_pulse", {15'd0, mem_resp}, 16'd0);
    check("busy_end", {15'd0, busy}, 16'd0);
    check("rdata_hold", mem_rdata, last_rd);
  endtask
  initial begin
    int n;
    logic seen;
    logic [9:0] k;
    do_reset();
    repeat (5) @(negedge clk);
    check("rst_resp", {15'd0, mem_resp}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_rdata", mem_rdata, 16'h0000);
    check("rst_proto", {15'd0, proto_err}, 16'd0);
    xact(0, 1, 2'b11, 16'h0040, 16'hBEEF);
    xact(1, 0, 2'b00, 16'h0040, 16'h0000);
    xact(0, 1, 2'b01, 16'h0040, 16'h1234);
    xact(1, 0, 2'b00, 16'h0040, 16'h0000);
    xact(0, 1, 2'b10, 16'h0040, 16'h5600);
    xact(1, 0, 2'b00, 16'h0040, 16'h0000);
    xact(0, 1, 2'b00, 16'h0040, 16'hFFFF);
    xact(1, 0, 2'b00, 16'h0040, 16'h0000);
    xact(0, 1, 2'b11, 16'h0002, 16'hAAAA);
    xact(1, 0, 2'b00, 16'h0802, 16'h0000);
    xact(1, 0, 2'b00, 16'h0003, 16'h0000);
    check("proto_clean", {15'd0, proto_err}, 16'd0);
    // Reset in the middle of a write's wait period must discard it.
    xact(0, 1, 2'b11, 16'h0010, 16'h5A5A);
    @(negedge clk);
    mem_write = 1; mem_byte_enable = 2'b11; mem_address = 16'h0010; mem_wdata = 16'h1111;
    seen = 0;
    repeat (2) begin @(negedge clk); seen |= mem_resp; end
    rst = 1; mem_write = 0;
    @(negedge clk);
    seen |= mem_resp;
    rst = 0;
    last_rd = 0;
    repeat (LAT + 2) begin @(negedge clk); seen |= mem_resp; end
    check("rstmid_noresp", {15'd0, seen}, 16'd0);
    check("rstmid_busy", {15'd0, busy}, 16'd0);
    check("rstmid_rdata", mem_rdata, 16'h0000);
    xact(1, 0, 2'b00, 16'h0010, 16'h0000);
    // Random traffic over a small set of preloaded words, with aliasing upper bits and bit 0.
    for (int j = 0; j < 16; j++) xact(0, 1, 2'b11, {5'd0, 10'(j * 37), 1'b0}, 16'($urandom));
    for (int j = 0; j < 80; j++) begin
      bit rd;
      rd = 1'($urandom);
      k = 10'($urandom_range(0, 15) * 37);
      xact(rd, !rd, 2'($urandom), {5'($urandom), k, 1'($urandom)}, 16'($urandom));
    end
    check("proto_rand", {15'd0, proto_err}, 16'd0);
    // Read and write together are served as a write.
    xact(1, 1, 2'b11, 16'h0020, 16'hC0DE);
    check("proto_both", {15'd0, proto_err}, PE);
    xact(1, 0, 2'b00, 16'h0020, 16'h0000);
    do_reset();
    check("proto_clr", {15'd0, proto_err}, 16'd0);
    // Dropping a held read during the wait still completes but is flagged.
    @(negedge clk);
    mem_read = 1; mem_address = 16'h0040; mem_wdata = 16'h0000;
    repeat (2) @(negedge clk);
    mem_read = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_resp && n < 40);
    check("drop_latency", 16'(n), 16'(LAT - 2));
    check("drop_rdata", mem_rdata, mdl[10'h020]);
    repeat (3) @(negedge clk);
    check("proto_drop", {15'd0, proto_err}, PE);
    repeat (5) @(negedge clk);
    check("proto_sticky", {15'd0, proto_err}, PE);
    do_reset();
    check("proto_rst", {15'd0, proto_err}, 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
